// File: rtl/fft_bfly_addr_gen.sv
// Radix-2 FFT butterfly address generator.
// Each stage pass walks k = 0..N/2-1 and emits one operand pair and one twiddle index per handshake.
// All outputs come from registered state (k, s, FSM state); there is no combinational path from the inputs.
module fft_bfly_addr_gen #(
    parameter int LOG2N = 5,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    stage,
    input  logic          bf_ready,
    output logic          busy,
    output logic          bf_valid,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [AW-2:0] tw_idx,
    output logic          last_bf,
    output logic          stage_done,
    output logic          stage_err
);
    localparam int N  = 1 << LOG2N;
    localparam int KW = AW - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k;
    logic [2:0]    s;
    logic          stage_ok;
    logic          k_last;
    logic          handshake;
    logic [AW-1:0] span, group, pos;

    assign stage_ok  = (int'(stage) < LOG2N);
    assign k_last    = (k == KW'(N / 2 - 1));
    assign handshake = bf_valid & bf_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: start only matters in IDLE; DONE always lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && stage_ok) state_nxt = RUN;
            RUN:     if (handshake && k_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        busy       = (state == RUN) || (state == DONE);
        bf_valid   = (state == RUN);
        stage_done = (state == DONE);
        last_bf    = (state == RUN) && k_last;
    end

    // Stage latch, butterfly counter and error pulse; k holds on the final handshake so it never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            s         <= '0;
            stage_err <= 1'b0;
        end else begin
            stage_err <= (state == IDLE) && start && !stage_ok;
            if (state == IDLE && start && stage_ok) begin
                s <= stage;
                k <= '0;
            end else if (handshake && !k_last) begin
                k <= k + KW'(1);
            end
        end
    end

    // Address math: split k into group (high bits) and position within the span (low s bits)
    always_comb begin
        span   = AW'(1) << s;
        group  = AW'(k) >> s;
        pos    = AW'(k) & (span - AW'(1));
        addr_a = (group << (s + 3'd1)) | pos;
        addr_b = addr_a + span;
        tw_idx = KW'(pos << (LOG2N - 1 - int'(s)));
    end
endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Directed bench for fft_bfly_addr_gen (N=32).
module tb_fft_bfly_addr_gen;
    logic       clk = 1'b0;
    logic       rst, start, bf_ready;
    logic [2:0] stage;
    logic       busy, bf_valid, last_bf, stage_done, stage_err;
    logic [4:0] addr_a, addr_b;
    logic [3:0] tw_idx;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hs    = 0;
    logic [31:0] seen  = '0;

    fft_bfly_addr_gen #(.LOG2N(5), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage), .bf_ready(bf_ready),
        .busy(busy), .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b),
        .tw_idx(tw_idx), .last_bf(last_bf), .stage_done(stage_done), .stage_err(stage_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Records the handshake that the coming edge will take, then advances to 1 time unit past the edge
    task automatic cyc();
        if (bf_valid === 1'b1 && bf_ready === 1'b1) begin
            hs++;
            seen[addr_a] = 1'b1;
            seen[addr_b] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string tag, input int a, input int b, input int tw);
        chk({tag, ".a"},  32'(addr_a), 32'(a));
        chk({tag, ".b"},  32'(addr_b), 32'(b));
        chk({tag, ".tw"}, 32'(tw_idx), 32'(tw));
    endtask

    task automatic run_to_done();
        int n = 0;
        while (stage_done !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stage = 3'd0; bf_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        // reset state
        chk("rst.busy", 32'(busy), 0);
        chk("rst.valid", 32'(bf_valid), 0);
        chk("rst.last", 32'(last_bf), 0);
        chk("rst.done", 32'(stage_done), 0);
        chk("rst.err", 32'(stage_err), 0);
        chk_pair("rst", 0, 1, 0);

        // stage 0 pass
        start = 1'b1; stage = 3'd0; hs = 0; seen = '0;
        cyc();
        start = 1'b0;
        chk("s0.valid", 32'(bf_valid), 1);
        chk("s0.busy", 32'(busy), 1);
        chk_pair("s0k0", 0, 1, 0);
        cyc();
        chk_pair("s0k1", 2, 3, 0);
        chk("s0k1.last", 32'(last_bf), 0);
        repeat (14) cyc();
        chk_pair("s0k15", 30, 31, 0);
        chk("s0k15.last", 32'(last_bf), 1);
        cyc();
        chk("s0.done", 32'(stage_done), 1);
        chk("s0.done_busy", 32'(busy), 1);
        chk("s0.done_valid", 32'(bf_valid), 0);
        chk("s0.hs", 32'(hs), 16);
        chk("s0.cover", seen, 32'hFFFF_FFFF);
        cyc();
        chk("s0.idle_busy", 32'(busy), 0);
        chk("s0.idle_done", 32'(stage_done), 0);

        // stage 2 pass
        start = 1'b1; stage = 3'd2; hs = 0; seen = '0;
        cyc();
        start = 1'b0;
        chk_pair("s2k0", 0, 4, 0);
        repeat (3) cyc();
        chk_pair("s2k3", 3, 7, 12);
        cyc();
        chk_pair("s2k4", 8, 12, 0);
        run_to_done();
        chk("s2.done", 32'(stage_done), 1);
        chk("s2.hs", 32'(hs), 16);
        chk("s2.cover", seen, 32'hFFFF_FFFF);
        // start during DONE is dropped; held into IDLE it is taken one cycle later
        start = 1'b1; stage = 3'd4;
        cyc();
        chk("done_start.busy", 32'(busy), 0);
        chk("done_start.valid", 32'(bf_valid), 0);
        hs = 0; seen = '0;
        cyc();
        start = 1'b0; stage = 3'd1;   // must not disturb the latched stage
        chk("s4.valid", 32'(bf_valid), 1);
        repeat (5) cyc();
        chk_pair("s4k5", 5, 21, 5);
        repeat (10) cyc();
        chk_pair("s4k15", 15, 31, 15);
        chk("s4k15.last", 32'(last_bf), 1);
        cyc();
        chk("s4.done", 32'(stage_done), 1);
        chk("s4.hs", 32'(hs), 16);
        chk("s4.cover", seen, 32'hFFFF_FFFF);
        cyc();

        // stage 1 pass with a 3-cycle stall at k=2 (pos=0 there, so tw=0)
        start = 1'b1; stage = 3'd1; hs = 0; seen = '0;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        chk_pair("s1k2", 4, 6, 0);
        bf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_pair("s1stall", 4, 6, 0);
            chk("s1stall.valid", 32'(bf_valid), 1);
        end
        bf_ready = 1'b1;
        cyc();
        chk_pair("s1k3", 5, 7, 8);
        run_to_done();
        chk("s1.done", 32'(stage_done), 1);
        chk("s1.hs", 32'(hs), 16);
        chk("s1.cover", seen, 32'hFFFF_FFFF);
        cyc();

        // out-of-range stage
        start = 1'b1; stage = 3'd5;
        cyc();
        start = 1'b0;
        chk("err.pulse", 32'(stage_err), 1);
        chk("err.busy", 32'(busy), 0);
        chk("err.valid", 32'(bf_valid), 0);
        cyc();
        chk("err.clear", 32'(stage_err), 0);
        chk("err.busy2", 32'(busy), 0);

        // reset mid-pass at k=7 of stage 3, with start also asserted to confirm reset wins
        start = 1'b1; stage = 3'd3;
        cyc();
        start = 1'b0;
        repeat (7) cyc();
        chk_pair("s3k7", 7, 15, 14);
        rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        chk("abort.valid", 32'(bf_valid), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(stage_done), 0);
        chk_pair("abort", 0, 1, 0);
        cyc();
        chk("abort.done2", 32'(stage_done), 0);
        chk("abort.busy2", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
